// File: rtl/uart_pkg.sv
// Shared constants, state encodings and width helpers for the UART.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_cfg_tick.sv
// Oversampling tick generator: down-counter, one tick every DIV clocks.
// restart reloads the counter so the first tick lands DIV clocks later.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count down to terminal count, then reload.
  always_ff @(posedge clk) begin
    if (rst || restart) cnt <= RELOAD;
    else if (cnt == '0) cnt <= RELOAD;
    else                cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_cfg.sv
// Full-duplex UART with configurable width, parity, stop bits and oversampling.
//
// RX states
//   RX_IDLE      | waiting for falling edge on rx_s
//   RX_START     | start bit; majority 1 means glitch, back to idle
//   RX_DATA      | shifting DATA_BITS bits, LSB first
//   RX_PARITY    | capturing parity bit
//   RX_STOP      | first stop bit decides valid / frame error / break
//   RX_WAIT_HIGH | after a bad stop, wait for a full bit period of idle line
// TX states
//   TX_IDLE      | tx_ready high, line idle
//   TX_START     | start bit
//   TX_DATA      | data bits, LSB first
//   TX_PARITY    | parity bit
//   TX_STOP      | STOP_BITS stop bits
module uart_cfg
  import uart_pkg::*;
#(
  parameter int CLOCKFRQ   = 48_000_000,
  parameter int BAUDRATE   = 4_000_000,
  parameter int OVERSAMPLE = 4,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam int DIV = CLOCKFRQ / (BAUDRATE * OVERSAMPLE);
  localparam int PW  = cnt_w(OVERSAMPLE);
  localparam int BW  = cnt_w(DATA_BITS);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] S_FIRST = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] S_LAST  = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_cfg: clocks per tick is zero");
  end

  function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  // ---------------- RX ----------------
  logic            rx_q1, rx_s, rx_s_d;
  rx_state_t       rx_state;
  logic [PW-1:0]   rx_phase, rx_ph_nx;
  logic [BW-1:0]   rx_bit;
  logic [1:0]      rx_samp;
  logic [DATA_BITS-1:0] rx_sr;
  logic            rx_par;
  logic            rx_tick, rx_restart, rx_fall, rx_wrap, rx_is_samp, rx_last, rx_maj;

  // Two-flop synchroniser plus one delay stage for edge detect; preset idle-high.
  always_ff @(posedge clk) begin
    if (rst) {rx_q1, rx_s, rx_s_d} <= 3'b111;
    else     {rx_q1, rx_s, rx_s_d} <= {rx, rx_q1, rx_s};
  end

  assign rx_fall    = rx_s_d && !rx_s;
  assign rx_restart = (rx_state == RX_IDLE) && rx_fall;
  assign rx_ph_nx   = rx_phase + 1'b1;
  // The restart moment counts as tick 0 of the bit; rx_ph_nx is the index of the current tick.
  assign rx_wrap    = rx_tick && (rx_phase == PH_LAST);
  assign rx_is_samp = rx_tick && (rx_phase != PH_LAST) && (rx_ph_nx >= S_FIRST) && (rx_ph_nx <= S_LAST);
  assign rx_last    = rx_tick && (rx_phase != PH_LAST) && (rx_ph_nx == S_LAST);
  assign rx_maj     = (rx_samp[1] & rx_samp[0]) | (rx_samp[1] & rx_s) | (rx_samp[0] & rx_s);

  uart_tick_gen #(.DIV(DIV)) u_rx_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (rx_restart),
    .tick    (rx_tick)
  );

  // Receive FSM: per-bit phase counting, 3-sample majority, stop-bit decision and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state      <= RX_IDLE;
      rx_phase      <= '0;
      rx_bit        <= '0;
      rx_samp       <= '0;
      rx_sr         <= '0;
      rx_par        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_break      <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_break      <= 1'b0;
      if (rx_is_samp) rx_samp <= {rx_samp[0], rx_s};
      if (rx_tick && (rx_state inside {RX_START, RX_DATA, RX_PARITY, RX_STOP}))
        rx_phase <= rx_wrap ? '0 : rx_ph_nx;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_phase <= '0;
            rx_busy  <= 1'b1;
          end
        end
        RX_START: begin
          if (rx_last && rx_maj) begin
            rx_state <= RX_IDLE;
            rx_busy  <= 1'b0;
          end else if (rx_wrap) begin
            rx_state <= RX_DATA;
            rx_bit   <= '0;
          end
        end
        RX_DATA: begin
          if (rx_last) rx_sr <= {rx_maj, rx_sr[DATA_BITS-1:1]};
          if (rx_wrap) begin
            if (rx_bit == LAST_DATA)
              rx_state <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
            else
              rx_bit <= rx_bit + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_last) rx_par <= rx_maj;
          if (rx_wrap) rx_state <= RX_STOP;
        end
        RX_STOP: begin
          if (rx_last) begin
            if (rx_maj) begin
              rx_data       <= rx_sr;
              rx_valid      <= 1'b1;
              rx_parity_err <= (PARITY != PARITY_NONE) && (rx_par != calc_par(rx_sr));
              rx_state      <= RX_IDLE;
              rx_busy       <= 1'b0;
            end else begin
              if ((rx_sr == '0) && ((PARITY == PARITY_NONE) || !rx_par)) rx_break <= 1'b1;
              else                                                        rx_frame_err <= 1'b1;
              rx_state <= RX_WAIT_HIGH;
              rx_phase <= '0;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_tick) begin
            if (!rx_s) rx_phase <= '0;
            else if (rx_phase == PH_LAST) begin
              rx_state <= RX_IDLE;
              rx_busy  <= 1'b0;
            end else rx_phase <= rx_phase + 1'b1;
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          rx_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- TX ----------------
  tx_state_t            tx_state;
  logic [PW-1:0]        tx_phase;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_sr;
  logic                 tx_par;
  logic                 tx_tick, tx_restart, tx_wrap;

  assign tx_restart = (tx_state == TX_IDLE) && tx_valid && tx_ready;
  assign tx_wrap    = tx_tick && (tx_phase == PH_LAST);

  uart_tick_gen #(.DIV(DIV)) u_tx_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (tx_restart),
    .tick    (tx_tick)
  );

  // Transmit FSM: every symbol lasts OVERSAMPLE ticks; line driven from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_phase <= '0;
      tx_bit   <= '0;
      tx_sr    <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      if (tx_tick && (tx_state != TX_IDLE)) tx_phase <= tx_wrap ? '0 : tx_phase + 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_sr    <= tx_data;
            tx_par   <= calc_par(tx_data);
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            tx_phase <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_wrap) begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            tx       <= tx_sr[0];
          end
        end
        TX_DATA: begin
          if (tx_wrap) begin
            if (tx_bit == LAST_DATA) begin
              tx_bit <= '0;
              if (PARITY != PARITY_NONE) begin
                tx_state <= TX_PARITY;
                tx       <= tx_par;
              end else begin
                tx_state <= TX_STOP;
                tx       <= 1'b1;
              end
            end else begin
              tx_bit <= tx_bit + 1'b1;
              tx_sr  <= tx_sr >> 1;
              tx     <= tx_sr[1];
            end
          end
        end
        TX_PARITY: begin
          if (tx_wrap) begin
            tx_state <= TX_STOP;
            tx_bit   <= '0;
            tx       <= 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_wrap) begin
            if (tx_bit == LAST_STOP) begin
              tx_state <= TX_IDLE;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else tx_bit <= tx_bit + 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
